// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command into one
// SETUP/ACCESS transfer and reports completion or timeout on a one-cycle response.
module apb_master #(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [1:0]          cmd_addr,
    input  logic [BITWIDTH-1:0] cmd_wdata,
    output logic                rsp_valid,
    output logic [BITWIDTH-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [1:0]          paddr,
    output logic [BITWIDTH-1:0] pwdata,
    input  logic [BITWIDTH-1:0] prdata,
    input  logic                pready
);

    localparam int unsigned CNT_W = 8;
    // Count value seen on the TIMEOUT-th ACCESS cycle (counter starts at 0).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE);

    // Transfer sequencing with all APB and response outputs registered.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state   <= SETUP;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_write ? cmd_wdata : '0;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    // pready takes priority over a timeout on the same cycle.
                    if (pready) begin
                        state     <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= pwrite ? '0 : prdata;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        wait_cnt <= CNT_W'(wait_cnt + CNT_W'(1));
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait write, wait-stated read, timeout,
// pready on the last permitted cycle, back-to-back commands and mid-transfer reset.
module tb_apb_master;

    localparam int unsigned BW = 8;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [1:0]    cmd_addr;
    logic [BW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [BW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [1:0]    paddr;
    logic [BW-1:0] pwdata;
    logic [BW-1:0] prdata;
    logic          pready;

    int n_checks = 0;
    int n_err    = 0;

    apb_master #(.BITWIDTH(BW), .TIMEOUT(15)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_acc;

        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 2'd0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        tick();
        tick();
        check("rst_psel",      32'(psel),      32'h0);
        check("rst_penable",   32'(penable),   32'h0);
        check("rst_pwrite",    32'(pwrite),    32'h0);
        check("rst_paddr",     32'(paddr),     32'h0);
        check("rst_pwdata",    32'(pwdata),    32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_err",   32'(rsp_err),   32'h0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        preset = 1'b0;
        tick();

        // Zero-wait write addr 0 data 0x1A
        pready    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 2'd0;
        cmd_wdata = 8'h1A;
        tick();
        cmd_valid = 1'b0;
        check("wr_setup_psel",    32'(psel),      32'h1);
        check("wr_setup_penable", 32'(penable),   32'h0);
        check("wr_setup_ready",   32'(cmd_ready), 32'h0);
        check("wr_setup_rsp",     32'(rsp_valid), 32'h0);
        tick();
        check("wr_acc_psel",    32'(psel),    32'h1);
        check("wr_acc_penable", 32'(penable), 32'h1);
        check("wr_acc_pwrite",  32'(pwrite),  32'h1);
        check("wr_acc_paddr",   32'(paddr),   32'h0);
        check("wr_acc_pwdata",  32'(pwdata),  32'h1A);
        tick();
        check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        check("wr_rsp_err",   32'(rsp_err),   32'h0);
        check("wr_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("wr_end_psel",  32'(psel),      32'h0);
        check("wr_end_ready", 32'(cmd_ready), 32'h1);
        tick();
        check("wr_rsp_pulse", 32'(rsp_valid), 32'h0);

        // Read addr 2 with four wait states then prdata 0xC3
        pready    = 1'b0;
        prdata    = 8'h77;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd2;
        cmd_wdata = 8'hEE;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 2'd1;
        check("rd_setup_pwrite", 32'(pwrite), 32'h0);
        check("rd_setup_pwdata", 32'(pwdata), 32'h0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            check("rd_wait_penable", 32'(penable),   32'h1);
            check("rd_wait_paddr",   32'(paddr),     32'h2);
            check("rd_wait_rsp",     32'(rsp_valid), 32'h0);
            tick();
        end
        check("rd_acc5_penable", 32'(penable), 32'h1);
        check("rd_acc5_paddr",   32'(paddr),   32'h2);
        pready = 1'b1;
        prdata = 8'hC3;
        tick();
        pready = 1'b0;
        prdata = 8'h00;
        check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd_rsp_rdata", 32'(rsp_rdata), 32'hC3);
        check("rd_rsp_err",   32'(rsp_err),   32'h0);
        check("rd_end_psel",  32'(psel),      32'h0);
        tick();

        // Timeout: pready held low
        prdata    = 8'hAA;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_acc = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) break;
            if (penable) n_acc++;
            tick();
        end
        check("to_rsp_seen",   32'(rsp_valid), 32'h1);
        check("to_acc_cycles", 32'(n_acc),     32'd15);
        check("to_rsp_err",    32'(rsp_err),   32'h1);
        check("to_rsp_rdata",  32'(rsp_rdata), 32'h0);
        check("to_psel",       32'(psel),      32'h0);
        check("to_penable",    32'(penable),   32'h0);
        tick();

        // pready rises on the 15th ACCESS cycle: completion wins
        prdata    = 8'h55;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 1; i <= 14; i++) tick();
        check("edge_acc15_penable", 32'(penable),   32'h1);
        check("edge_acc15_rsp",     32'(rsp_valid), 32'h0);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        check("edge_rsp_valid", 32'(rsp_valid), 32'h1);
        check("edge_rsp_err",   32'(rsp_err),   32'h0);
        check("edge_rsp_rdata", 32'(rsp_rdata), 32'h55);
        tick();

        // Back-to-back writes with cmd_valid held high
        pready    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 2'd0;
        cmd_wdata = 8'h11;
        tick();
        cmd_addr  = 2'd2;
        cmd_wdata = 8'h22;
        tick();
        check("b2b_1_paddr",  32'(paddr),  32'h0);
        check("b2b_1_pwdata", 32'(pwdata), 32'h11);
        tick();
        check("b2b_1_rsp",   32'(rsp_valid), 32'h1);
        check("b2b_gap_psel", 32'(psel),     32'h0);
        check("b2b_gap_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        check("b2b_2_psel",    32'(psel),      32'h1);
        check("b2b_2_penable", 32'(penable),   32'h0);
        check("b2b_2_paddr",   32'(paddr),     32'h2);
        check("b2b_2_pwdata",  32'(pwdata),    32'h22);
        check("b2b_2_norsp",   32'(rsp_valid), 32'h0);
        tick();
        tick();
        check("b2b_2_rsp",     32'(rsp_valid), 32'h1);
        check("b2b_2_rsp_err", 32'(rsp_err),   32'h0);
        tick();

        // Reset during ACCESS aborts silently
        pready    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 2'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rstacc_penable", 32'(penable), 32'h1);
        preset = 1'b1;
        tick();
        check("rstacc_psel",    32'(psel),      32'h0);
        check("rstacc_penable0", 32'(penable),  32'h0);
        check("rstacc_norsp",   32'(rsp_valid), 32'h0);
        preset = 1'b0;
        pready = 1'b1;
        check("rstacc_ready", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstacc_quiet", 32'(rsp_valid), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 BITWIDTH, default 8, data width of command, response and APB data buses.
REQ-002 TIMEOUT, default 15, max ACCESS cycles with pready low before abort; legal range 1..255.
REQ-003 pclk  input  1  sole clock; all state changes on rising edge.
REQ-004 preset  input  1  reset; synchronous and active-high.
REQ-005 cmd_valid  input  1  request present.
REQ-006 cmd_ready  output  1  block accepts request this cycle.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  2  target register address.
REQ-009 cmd_wdata  input  BITWIDTH  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  BITWIDTH  read data for completed read.
REQ-012 rsp_err  output  1  qualifies rsp_valid; 1 = timeout abort.
REQ-013 psel  output  1  APB select.
REQ-014 penable  output  1  APB enable.
REQ-015 pwrite  output  1  APB direction.
REQ-016 paddr  output  2  APB address.
REQ-017 pwdata  output  BITWIDTH  APB write data.
REQ-018 prdata  input  BITWIDTH  APB read data from slave.
REQ-019 pready  input  1  slave completion.

Function
REQ-020 FSM states IDLE, SETUP, ACCESS; all APB and rsp outputs registered.
REQ-021 cmd_ready = 1 iff state is IDLE (combinational from state).
REQ-022 IDLE: cmd_valid=1 -> capture cmd_write/addr/wdata into pwrite/paddr/pwdata, psel=1, penable=0, go SETUP next edge.
REQ-023 SETUP lasts exactly one cycle -> ACCESS with psel=1, penable=1, wait counter cleared.
REQ-024 pwrite, paddr, pwdata stable from SETUP through last ACCESS cycle; pwdata = 0 for reads.
REQ-025 ACCESS with pready=1 -> next edge: psel=0, penable=0, IDLE, rsp_valid=1, rsp_err=0; read: rsp_rdata=prdata sampled that edge; write: rsp_rdata=0.
REQ-026 ACCESS with pready=0 -> stay ACCESS, counter increments (8-bit, saturating irrelevant since abort at TIMEOUT).
REQ-027 Counter reaching TIMEOUT with pready still 0 -> next edge: IDLE, psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-028 pready=1 on the same cycle the counter hits TIMEOUT -> normal completion (pready wins).
REQ-029 rsp_valid high exactly one cycle; no backpressure on response.
REQ-030 Zero-wait transfer: accept-to-rsp_valid latency 3 edges (IDLE->SETUP->ACCESS->IDLE); back-to-back commands possible every 3 cycles, psel low for one IDLE cycle between.
REQ-031 cmd_* ignored outside IDLE; pready/prdata ignored outside ACCESS.

Reset
REQ-032 preset=1 at rising edge -> IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
REQ-033 Reset in SETUP or ACCESS aborts transfer silently: no rsp_valid pulse; cmd_ready=1 first cycle after reset release.

Verification
REQ-034 Write addr=0 data=0x1A, pready tied 1 -> SETUP cycle psel=1/penable=0, ACCESS psel=1/penable=1 pwrite=1 paddr=0 pwdata=0x1A, rsp_valid 3 edges after accept, rsp_err=0.
REQ-035 Read addr=2, slave holds pready=0 for 4 ACCESS cycles then 1 with prdata=0xC3 -> ACCESS lasts 5 cycles, addr stable, rsp_rdata=0xC3, rsp_err=0.
REQ-036 Read with pready held 0, TIMEOUT=15 -> exactly 15 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, psel=0.
REQ-037 pready rises on the TIMEOUT-th ACCESS cycle with prdata=0x55 -> rsp_err=0, rsp_rdata=0x55.
REQ-038 cmd_valid held 1 with two queued writes (addr 0 then 2) -> second accepted only in IDLE, one psel-low cycle between, each with its own rsp_valid pulse.
REQ-039 preset=1 asserted during ACCESS -> next edge psel=0, penable=0, no rsp_valid ever for that transfer, cmd_ready=1 after release.
